dmem_req: RTL and testbench
===========================

// Module: dmem_req
// PURPOSE
//  Request-issue stage for the data SRAM-like bus; sits directly upstream of the load-return stage dmem.
//  Takes one load/store per accept from the MEM stage and checks alignment.
//  Builds the bus request (size, wstrb, lane-replicated wdata, mapped address) and runs the req/addr_ok/data_ok handshake.
//  Stalls the pipeline until data_ok; drives req/data_pending, which dmem consumes alongside data_ok/rdata.
// PARAMETERS
//  ADDR_MAP   1   1: physical addr = {3'b000, vaddr[28:0]} (kseg0/kseg1 fold); 0: addr passes unchanged
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rst         in   1   synchronous, active-high reset
//  mem_valid   in   1   MEM stage holds a memory op this cycle
//  mem_we      in   1   1 store, 0 load
//  mem_addr    in   32  virtual byte address
//  mem_wd      in   32  store data, right-aligned
//  mem_width   in   2   00 none, 01 byte, 10 half, 11 word
//  mem_flush   in   1   exception/flush from later stage; cancels the op in flight
//  req         out  1   bus request
//  wr          out  1   bus write
//  size        out  2   0 byte, 1 half, 2 word
//  addr        out  32  bus byte address (mapped per ADDR_MAP)
//  wstrb       out  4   byte enables; 0 for loads
//  wdata       out  32  store data replicated to all lanes
//  addr_ok     in   1   address accepted this cycle
//  data_ok     in   1   data returned / write done this cycle
//  stall       out  1   hold the pipeline
//  done        out  1   one-cycle pulse: op completed (same cycle as the accepted data_ok)
//  data_pending out 1   1 from the addr_ok handshake until data_ok
//  exc_adel    out  1   misaligned load (ADDR_EXC_EN only; else tied 0)
//  exc_ades    out  1   misaligned store (ADDR_EXC_EN only; else tied 0)
//  badvaddr    out  32  faulting virtual address (ADDR_EXC_EN only; else 0)
// BEHAVIOUR
//  - Reset: state=IDLE. req, wr, size, addr, wstrb, wdata, done, data_pending, exc_* and badvaddr all 0.
//  - accept = IDLE & mem_valid & mem_width!=00 & aligned & !mem_flush.
//  - Aligned means: half needs addr[0]=0; word needs addr[1:0]=00.
//  - FSM IDLE->REQ on accept; the request fields are registered at that edge.
//  - FSM REQ->WAIT on addr_ok. REQ->IDLE on mem_flush without addr_ok (req drops; legal before addr_ok).
//  - FSM REQ->CANCEL on mem_flush with addr_ok.
//  - FSM WAIT->IDLE on data_ok, with done=1 unless mem_flush in the same cycle. WAIT->CANCEL on mem_flush without data_ok.
//  - FSM CANCEL->IDLE on data_ok; data is discarded and done stays 0.
//  - req=1 only in REQ; fields are held stable in REQ.
//  - data_pending=1 in WAIT and CANCEL.
//  - Minimum latency: accept cycle N, req at N+1, done at N+2 when addr_ok and data_ok each arrive 1 cycle later.
//  - addr_ok and data_ok in the same cycle in REQ: go to WAIT; data_ok is treated as a bus protocol violation and ignored.
//  - stall=1 when IDLE & accept, or REQ, or WAIT & !data_ok, or CANCEL & mem_valid. stall is 0 in the done cycle.
//  - No new accept in CANCEL. One op outstanding, max.
//  - Byte: wstrb=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}.
//  - Half: wstrb=addr[1]?1100:0011, wdata={2{wd[15:0]}}.
//  - Word: wstrb=1111, wdata=wd.
//  - Loads: wstrb=0000, wdata=0.
//  - mem_width=00: no accept, no stall, stays IDLE.
//  - rst in any state: back to IDLE next edge and outputs cleared. The bus agent is reset by the same rst; no data_ok is awaited.
// CONFIGURATION
//  ADDR_EXC_EN defined:
//  - A misaligned op in IDLE issues no request.
//  - It pulses exc_adel (load) or exc_ades (store) for 1 cycle, registered, in the cycle after mem_valid.
//  - badvaddr latches mem_addr. stall=0 on that op.
//  ADDR_EXC_EN undefined:
//  - No alignment check. addr[0] is forced 0 for half; addr[1:0] is forced 00 for word.
//  - exc_* and badvaddr are tied 0.
// TESTING
//  - Word store A=0x8000_0104, wd=0xDEADBEEF, addr_ok +1 and data_ok +1 -> req 1 cycle, addr=0x0000_0104, wstrb=1111, size=2, done at accept+3.
//  - Byte store A=..0103, wd=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5, size=0.
//  - Half load A=..0002, addr_ok delayed 3 cycles -> req held 4 cycles with stable addr/size=1, wstrb=0000; stall until data_ok.
//  - Flush in WAIT, data_ok 2 cycles later -> CANCEL, no done, data_pending=1 until data_ok, then IDLE.
//  - Flush in REQ without addr_ok -> req drops next cycle, IDLE, no data_pending.
//  - ADDR_EXC_EN, word load A=0x1002 -> exc_adel=1 for 1 cycle, badvaddr=0x1002, no req. Without the macro: req with addr=0x1000.

Source files
------------

// File: rtl/dmem_req.sv
// Data-bus request issue stage: alignment check, lane steering and req/addr_ok/data_ok handshake.
// Optional macro ADDR_EXC_EN: misaligned ops raise exc_adel/exc_ades instead of being force-aligned.
`timescale 1ns/1ps
module dmem_req #(
  parameter int ADDR_MAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wd,
  input  logic [1:0]  mem_width,
  input  logic        mem_flush,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  output logic        stall,
  output logic        done,
  output logic        data_pending,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] badvaddr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_CANCEL} state_t;
  state_t state;

  logic width_ok;
  logic accept;

  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] w);
    case (w)
      2'b10:   return {a[31:1], 1'b0};
      2'b11:   return {a[31:2], 2'b00};
      default: return a;
    endcase
  endfunction

  // kseg0/kseg1 fold: drop the top three segment bits
  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if (ADDR_MAP != 0) return {3'b000, a[28:0]};
    return a;
  endfunction

  function automatic logic [3:0] lane_strb(input logic we, input logic [1:0] w, input logic [1:0] lo);
    if (!we) return 4'b0000;
    case (w)
      2'b01:   return 4'b0001 << lo;
      2'b10:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic we, input logic [1:0] w, input logic [31:0] d);
    if (!we) return 32'h0;
    case (w)
      2'b01:   return {4{d[7:0]}};
      2'b10:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  assign width_ok = (mem_width != 2'b00);

`ifdef ADDR_EXC_EN
  logic aligned;
  logic misalign;

  always_comb begin
    aligned = 1'b1;
    if (mem_width == 2'b10) aligned = !mem_addr[0];
    if (mem_width == 2'b11) aligned = (mem_addr[1:0] == 2'b00);
  end

  assign accept   = (state == S_IDLE) && mem_valid && width_ok && aligned && !mem_flush;
  assign misalign = (state == S_IDLE) && mem_valid && width_ok && !aligned && !mem_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      badvaddr <= 32'h0;
    end else begin
      exc_adel <= misalign && !mem_we;
      exc_ades <= misalign && mem_we;
      if (misalign) badvaddr <= mem_addr;
    end
  end
`else
  assign accept   = (state == S_IDLE) && mem_valid && width_ok && !mem_flush;
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
  assign badvaddr = 32'h0;
`endif

  // Request fields are captured once at accept and held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req          <= 1'b0;
      wr           <= 1'b0;
      size         <= 2'b00;
      addr         <= 32'h0;
      wstrb        <= 4'b0000;
      wdata        <= 32'h0;
      data_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_REQ;
            req   <= 1'b1;
            wr    <= mem_we;
            size  <= mem_width - 2'd1;
            addr  <= map_addr(align_addr(mem_addr, mem_width));
            wstrb <= lane_strb(mem_we, mem_width, mem_addr[1:0]);
            wdata <= lane_data(mem_we, mem_width, mem_wd);
          end
        end
        S_REQ: begin
          // a data_ok coincident with addr_ok is a protocol violation and is ignored
          if (addr_ok) begin
            req          <= 1'b0;
            data_pending <= 1'b1;
            state        <= mem_flush ? S_CANCEL : S_WAIT;
          end else if (mem_flush) begin
            req   <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (data_ok) begin
            data_pending <= 1'b0;
            state        <= S_IDLE;
          end else if (mem_flush) begin
            state <= S_CANCEL;
          end
        end
        S_CANCEL: begin
          if (data_ok) begin
            data_pending <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign done  = (state == S_WAIT) && data_ok && !mem_flush;
  assign stall = ((state == S_IDLE) && accept) ||
                 (state == S_REQ) ||
                 ((state == S_WAIT) && !data_ok) ||
                 ((state == S_CANCEL) && mem_valid);

endmodule

// File: tb/tb_dmem_req.sv
// Scoreboard bench for dmem_req: stimulus pushes expected requests/done cycles, a monitor pops and compares.
`timescale 1ns/1ps
module tb_dmem_req;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_we, mem_flush, addr_ok, data_ok;
  logic [31:0] mem_addr, mem_wd;
  logic [1:0]  mem_width;
  logic        req, wr, stall, done, data_pending, exc_adel, exc_ades;
  logic [1:0]  size;
  logic [31:0] addr, wdata, badvaddr;
  logic [3:0]  wstrb;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  req_t sb_q[$];
  int   done_q[$];

  dmem_req dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_width(mem_width), .mem_flush(mem_flush), .req(req), .wr(wr),
    .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok),
    .data_ok(data_ok), .stall(stall), .done(done), .data_pending(data_pending),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: request fields compared every req cycle (stability), popped on the addr_ok handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (req) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexp_req actual=%h required=none", addr);
        end else begin
          chk("req_wr",    32'(wr),    32'(sb_q[0].wr));
          chk("req_size",  32'(size),  32'(sb_q[0].size));
          chk("req_addr",  addr,       sb_q[0].addr);
          chk("req_wstrb", 32'(wstrb), 32'(sb_q[0].wstrb));
          chk("req_wdata", wdata,      sb_q[0].wdata);
          if (addr_ok) void'(sb_q.pop_front());
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexp_done actual=%0d required=none", cyc);
        end else begin
          chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One full op: adly idle REQ cycles before addr_ok, ddly idle WAIT cycles before data_ok.
  task automatic run_op(input logic we, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] wd, input int adly, input int ddly,
                        input bit early, input req_t exp);
    int c0;
    mem_valid = 1'b1; mem_we = we; mem_width = w; mem_addr = a; mem_wd = wd;
    c0 = cyc;
    sb_q.push_back(exp);
    done_q.push_back(c0 + 2 + adly + ddly);
    @(negedge clk);
    chk("acc_stall", 32'(stall), 32'd1);
    chk("acc_noreq", 32'(req), 32'd0);
    for (int i = 0; i <= adly; i++) begin
      step();
      addr_ok = (i == adly);
      data_ok = early && (i == adly);
      @(negedge clk);
      chk("req_stall", 32'(stall), 32'd1);
      chk("req_nopend", 32'(data_pending), 32'd0);
    end
    for (int j = 0; j <= ddly; j++) begin
      step();
      addr_ok = 1'b0;
      data_ok = (j == ddly);
      @(negedge clk);
      chk("wait_pend", 32'(data_pending), 32'd1);
      chk("wait_stall", 32'(stall), 32'(j != ddly));
    end
    step();
    data_ok = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk("end_pend", 32'(data_pending), 32'd0);
    chk("end_stall", 32'(stall), 32'd0);
    step();
  endtask

  req_t e;

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wd = 32'h0;
    mem_width = 2'b00; mem_flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_size", 32'(size), 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_wstrb", 32'(wstrb), 32'd0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pend", 32'(data_pending), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_exc", 32'({exc_adel, exc_ades}), 32'd0);
    chk("rst_badva", badvaddr, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Word store, addr_ok in first req cycle, data_ok one cycle into WAIT: done at accept+3
    e = '{1'b1, 2'd2, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF};
    run_op(1'b1, 2'b11, 32'h8000_0104, 32'hDEAD_BEEF, 0, 1, 1'b0, e);
    // Byte store to lane 3, minimum latency
    e = '{1'b1, 2'd0, 32'h0000_0103, 4'b1000, 32'hA5A5_A5A5};
    run_op(1'b1, 2'b01, 32'h8000_0103, 32'h0000_00A5, 0, 0, 1'b0, e);
    // Half load, addr_ok delayed 3 cycles: req held 4 cycles
    e = '{1'b0, 2'd1, 32'h0000_0002, 4'b0000, 32'h0};
    run_op(1'b0, 2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 3, 0, 1'b0, e);
    // data_ok together with addr_ok in REQ is ignored; real data_ok follows
    e = '{1'b1, 2'd2, 32'h0000_0208, 4'b1111, 32'h0102_0304};
    run_op(1'b1, 2'b11, 32'h0000_0208, 32'h0102_0304, 0, 1, 1'b1, e);

    // Flush in REQ without addr_ok
    mem_valid = 1'b1; mem_we = 1'b1; mem_width = 2'b01; mem_addr = 32'h0000_0201; mem_wd = 32'h0000_005A;
    sb_q.push_back('{1'b1, 2'd0, 32'h0000_0201, 4'b0010, 32'h5A5A_5A5A});
    @(negedge clk); chk("fr_acc_stall", 32'(stall), 32'd1);
    step(); mem_flush = 1'b1;
    @(negedge clk); chk("fr_req", 32'(req), 32'd1);
    step(); mem_flush = 1'b0; mem_valid = 1'b0; void'(sb_q.pop_front());
    @(negedge clk);
    chk("fr_req_drop", 32'(req), 32'd0);
    chk("fr_nopend", 32'(data_pending), 32'd0);
    chk("fr_stall", 32'(stall), 32'd0);
    step();

    // Flush in WAIT, data_ok two cycles later -> CANCEL, no done
    mem_valid = 1'b1; mem_we = 1'b1; mem_width = 2'b10; mem_addr = 32'hA000_0006; mem_wd = 32'h1234_ABCD;
    sb_q.push_back('{1'b1, 2'd1, 32'h0000_0006, 4'b1100, 32'hABCD_ABCD});
    @(negedge clk);
    step(); addr_ok = 1'b1;
    @(negedge clk);
    step(); addr_ok = 1'b0; mem_flush = 1'b1;
    @(negedge clk); chk("fw_wait_pend", 32'(data_pending), 32'd1);
    step(); mem_flush = 1'b0;
    @(negedge clk);
    chk("fw_cancel_pend", 32'(data_pending), 32'd1);
    chk("fw_cancel_stall", 32'(stall), 32'd1);
    step(); data_ok = 1'b1; mem_valid = 1'b0;
    @(negedge clk);
    chk("fw_dok_done", 32'(done), 32'd0);
    chk("fw_dok_pend", 32'(data_pending), 32'd1);
    chk("fw_dok_stall", 32'(stall), 32'd0);
    step(); data_ok = 1'b0;
    @(negedge clk);
    chk("fw_idle_pend", 32'(data_pending), 32'd0);
    chk("fw_idle_req", 32'(req), 32'd0);
    step();

    // mem_width=00: nothing happens
    mem_valid = 1'b1; mem_we = 1'b0; mem_width = 2'b00; mem_addr = 32'h0000_0100;
    @(negedge clk); chk("w0_stall", 32'(stall), 32'd0);
    step();
    @(negedge clk); chk("w0_req", 32'(req), 32'd0);
    step(); mem_valid = 1'b0;

    // Reset while waiting for data
    mem_valid = 1'b1; mem_we = 1'b0; mem_width = 2'b11; mem_addr = 32'h0000_0040;
    sb_q.push_back('{1'b0, 2'd2, 32'h0000_0040, 4'b0000, 32'h0});
    @(negedge clk);
    step(); addr_ok = 1'b1;
    @(negedge clk);
    step(); addr_ok = 1'b0; rst = 1'b1;
    @(negedge clk); chk("rw_pend", 32'(data_pending), 32'd1);
    step(); rst = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk("rw_pend_clr", 32'(data_pending), 32'd0);
    chk("rw_addr_clr", addr, 32'h0);
    chk("rw_size_clr", 32'(size), 32'd0);
    chk("rw_stall", 32'(stall), 32'd0);
    step();

`ifdef ADDR_EXC_EN
    // Misaligned word load raises exc_adel, no request
    mem_valid = 1'b1; mem_we = 1'b0; mem_width = 2'b11; mem_addr = 32'h0000_1002;
    @(negedge clk); chk("mis_stall", 32'(stall), 32'd0);
    step(); mem_valid = 1'b0;
    @(negedge clk);
    chk("mis_adel", 32'(exc_adel), 32'd1);
    chk("mis_ades", 32'(exc_ades), 32'd0);
    chk("mis_badva", badvaddr, 32'h0000_1002);
    chk("mis_noreq", 32'(req), 32'd0);
    step();
    @(negedge clk); chk("mis_adel_pulse", 32'(exc_adel), 32'd0);
    step();
`else
    // Misaligned word load is force-aligned
    e = '{1'b0, 2'd2, 32'h0000_1000, 4'b0000, 32'h0};
    run_op(1'b0, 2'b11, 32'h0000_1002, 32'h0, 0, 0, 1'b0, e);
    @(negedge clk);
    chk("mis_exc_tied", 32'({exc_adel, exc_ades}), 32'd0);
    chk("mis_badva_tied", badvaddr, 32'h0);
    step();
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
